// File: rtl/keypad_row_scanner.sv
// 4x4 matrix keypad scanner: one-hot row drive, synchronised column sampling,
// press/release debouncing and reporting of one key code per accepted press.
module keypad_row_scanner #(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    col_lat_q, col_lat_d;
    logic [3:0]    cols_meta_q, cols_s_q;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_pressed_q, key_pressed_d;
    logic [CW-1:0] cnt_inc;

    // Lowest column index wins when several keys of the same row are closed.
    function automatic logic [1:0] lowest_bit(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    assign cnt_inc = (cnt_q < CNT_SAT) ? (cnt_q + CNT_ONE) : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_SCAN;
            cnt_q         <= '0;
            row_idx_q     <= 2'd0;
            col_lat_q     <= 4'd0;
            cols_meta_q   <= 4'd0;
            cols_s_q      <= 4'd0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            row_idx_q     <= row_idx_d;
            col_lat_q     <= col_lat_d;
            cols_meta_q   <= cols;
            cols_s_q      <= cols_meta_q;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_idx_d = row_idx_q;
        col_lat_d = col_lat_q;
        case (state_q)
            ST_SCAN: begin
                if (cnt_q >= SCAN_LAST) begin
                    cnt_d = '0;
                    if (cols_s_q != 4'd0) begin
                        col_lat_d = cols_s_q;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DEBOUNCE: begin
                if (cols_s_q == col_lat_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_q >= DEB_LAST) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d   = ST_SCAN;
                    cnt_d     = '0;
                    row_idx_d = row_idx_q + 2'd1;
                end
            end
            ST_PRESSED: begin
                if (cols_s_q == 4'd0) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cols_s_q != 4'd0) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q >= DEB_LAST) begin
                        state_d   = ST_SCAN;
                        cnt_d     = '0;
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
            end
        endcase
    end

    // Outputs are registered; a key is accepted only on the DEBOUNCE->PRESSED edge.
    always_comb begin
        key_valid_d   = (state_q == ST_DEBOUNCE) && (state_d == ST_PRESSED);
        key_code_d    = key_code_q;
        key_pressed_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
        if (key_valid_d) begin
            key_code_d = {row_idx_q, lowest_bit(col_lat_q)};
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_rows
        assign rows[gi] = (row_idx_q == 2'(gi));
    end

    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_row_scanner.sv
// Directed and randomized checks of keypad_row_scanner against a keypad model
// and timing/code expectations derived arithmetically from the scanner rules.
module tb_keypad_row_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 8;
    // Row active -> report: 2 sync stages, rest of the dwell, then the debounce run.
    localparam int PRESS_LAT   = 2 + (SCAN - 2) + DEB;
    // Release -> key_pressed low: 2 sync stages, one cycle to enter RELEASE, then the debounce run.
    localparam int RELEASE_LAT = 2 + 1 + DEB;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;
    logic [15:0] key_mat;

    int n_tests    = 0;
    int n_fail     = 0;
    int pulse_cnt  = 0;
    int consec_err = 0;
    bit prev_kv    = 1'b0;

    keypad_row_scanner #(
        .SCAN_CYCLES    (SCAN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cols       (cols),
        .rows       (rows),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_pressed(key_pressed)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a closed key connects its row line to its column line.
    always_comb begin
        cols = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (rows[r]) begin
                cols = cols | key_mat[r*4 +: 4];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (key_valid) begin
            pulse_cnt++;
            if (prev_kv) consec_err++;
        end
        prev_kv = key_valid;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int key_of(input int row, input logic [3:0] mask);
        for (int c = 0; c < 4; c++) begin
            if (mask[c]) return row * 4 + c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] row_onehot(input int row);
        logic [3:0] v;
        v = 4'd0;
        v[row % 4] = 1'b1;
        return v;
    endfunction

    // Returns at the first negedge after the target row becomes active.
    task automatic wait_row_enter(input int row, output bit ok);
        int n;
        n = 0;
        while (rows == row_onehot(row) && n < 100) begin @(negedge clk); n++; end
        while (rows != row_onehot(row) && n < 100) begin @(negedge clk); n++; end
        ok = (rows == row_onehot(row));
    endtask

    task automatic wait_pulse(input int budget, output int lat);
        int start;
        start = pulse_cnt;
        lat = 0;
        while (pulse_cnt == start && lat < budget) begin @(negedge clk); lat++; end
        if (pulse_cnt == start) lat = -1;
    endtask

    task automatic wait_kp_fall(input int budget, output int lat);
        lat = 0;
        while (key_pressed && lat < budget) begin @(negedge clk); lat++; end
    endtask

    initial begin
        int  lat;
        int  base;
        bit  ok;
        int  row;
        int  hold;
        int  exp_code;
        logic [3:0] mask;
        logic [3:0] bounce_val [10];
        bounce_val = '{4'd0, 4'd0, 4'd0, 4'd8, 4'd8, 4'd0, 4'd0, 4'd0, 4'd8, 4'd8};

        // Reset and idle scanning
        reset = 1'b1;
        key_mat = 16'd0;
        step(3);
        chk("rst_rows", rows, 4'b0001);
        chk("rst_code", key_code, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_pressed", key_pressed, 0);
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("scan_rows", rows, row_onehot((k / SCAN) % 4));
        end
        chk("scan_no_pulse", pulse_cnt, 0);

        // Clean press of row2/col1
        wait_row_enter(2, ok);
        chk("t2_row_enter", ok, 1);
        key_mat = 16'd1 << 9;
        wait_pulse(100, lat);
        chk("t2_press_lat", lat, PRESS_LAT);
        chk("t2_code", key_code, 9);
        chk("t2_pressed", key_pressed, 1);
        base = pulse_cnt;
        step(10);
        chk("t2_rows_frozen", rows, 4'b0100);
        chk("t2_single_pulse", pulse_cnt, base);
        key_mat = 16'd0;
        wait_kp_fall(60, lat);
        chk("t2_release_lat", lat, RELEASE_LAT);
        chk("t2_rows_after", rows, 4'b1000);

        // Dropout during debounce of row0/col3
        wait_row_enter(0, ok);
        chk("t3_row_enter", ok, 1);
        base = pulse_cnt;
        key_mat = 16'd1 << 3;
        step(6);
        key_mat = 16'd0;
        step(3);
        key_mat = 16'd1 << 3;
        step(5);
        chk("t3_no_early_pulse", pulse_cnt, base);
        wait_pulse(100, lat);
        chk("t3_pulse_seen", (lat > 0), 1);
        chk("t3_code", key_code, 3);

        // Release with re-contacts inside the release window
        step(3);
        base = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            key_mat = {12'd0, bounce_val[i]};
            @(negedge clk);
            chk("t4_pressed_hold", key_pressed, 1);
        end
        key_mat = 16'd0;
        wait_kp_fall(60, lat);
        chk("t4_release_lat", lat, RELEASE_LAT);
        chk("t4_no_second_pulse", pulse_cnt, base);

        // Second key in another row is masked until release
        wait_row_enter(0, ok);
        chk("t5_row_enter", ok, 1);
        key_mat = 16'd1 << 3;
        wait_pulse(100, lat);
        chk("t5_first_code", key_code, 3);
        key_mat = key_mat | (16'd1 << 4);
        base = pulse_cnt;
        step(30);
        chk("t5_masked_pulses", pulse_cnt, base);
        chk("t5_masked_code", key_code, 3);
        chk("t5_masked_rows", rows, 4'b0001);
        key_mat = 16'd1 << 4;
        wait_kp_fall(60, lat);
        chk("t5_release_lat", lat, RELEASE_LAT);
        chk("t5_rows_next", rows, 4'b0010);
        wait_pulse(100, lat);
        chk("t5_second_lat", lat, PRESS_LAT);
        chk("t5_second_code", key_code, 4);
        key_mat = 16'd0;
        wait_kp_fall(60, lat);
        chk("t5_final_release", lat, RELEASE_LAT);

        // Reset while a key is held
        wait_row_enter(1, ok);
        chk("t6_row_enter", ok, 1);
        key_mat = 16'd1 << 6;
        wait_pulse(100, lat);
        chk("t6_code", key_code, 6);
        step(3);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_rows", rows, 4'b0001);
        chk("t6_rst_pressed", key_pressed, 0);
        chk("t6_rst_valid", key_valid, 0);
        chk("t6_rst_code", key_code, 0);
        key_mat = 16'd0;
        step(2);
        reset = 1'b0;
        base = pulse_cnt;
        step(40);
        chk("t6_no_pulse_after", pulse_cnt, base);

        // Randomized presses, including several keys closed in the same row
        for (int it = 0; it < 6; it++) begin
            row  = int'($urandom_range(0, 3));
            mask = 4'($urandom_range(1, 15));
            exp_code = key_of(row, mask);
            step(int'($urandom_range(0, 20)));
            key_mat = 16'(mask) << (row * 4);
            wait_pulse(120, lat);
            chk("rnd_pulse_seen", (lat > 0), 1);
            chk("rnd_code", key_code, exp_code);
            chk("rnd_rows_frozen", rows, row_onehot(row));
            base = pulse_cnt;
            hold = int'($urandom_range(5, 30));
            step(hold);
            chk("rnd_single_pulse", pulse_cnt, base);
            chk("rnd_pressed", key_pressed, 1);
            key_mat = 16'd0;
            wait_kp_fall(60, lat);
            chk("rnd_release_lat", lat, RELEASE_LAT);
            chk("rnd_rows_next", rows, row_onehot(row + 1));
            $display("[TB] rnd press row=%0d mask=%b code=%0d hold=%0d", row, mask, exp_code, hold);
        end

        chk("no_consecutive_valid", consec_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
